rr_arb_4ch: RTL and testbench



---
 rtl/rr_arb_4ch_pkg.sv | 43 ++++
 rtl/rr_pick_4.sv | 27 ++
 rtl/rr_arb_4ch.sv | 89 ++++++++
 tb/tb_rr_arb_4ch.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_4ch_pkg.sv
// Shared definitions for the four-channel round-robin arbiter.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   NUM_CH, SEL_W  channel count and select width
//   state_e        output-stage occupancy (EMPTY / FULL)
//   pick_t         result of a round-robin search (found flag + index)
//   rr_pick()      rotate-and-priority-encode helper
package rr_arb_4ch_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // Search order is last+1, last+2, last+3, last+4 (mod 4). Walking the
  // offsets from farthest to nearest lets the nearest valid candidate
  // overwrite any earlier hit, so the first channel after `last` wins.
  function automatic pick_t rr_pick(input logic [NUM_CH-1:0] req,
                                    input logic [SEL_W-1:0]  last);
    pick_t            res;
    logic [SEL_W-1:0] cand;
    res = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = last + SEL_W'(k);
      if (req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Round-robin pick: rotate the request vector past the last grant and
// priority-encode the first requester.
// Latency: combinational. Backpressure: none (pure function of inputs).
//
// Ports:
//   req_i    per-channel request bits
//   last_i   index of the most recent grant
//   found_o  at least one request present
//   idx_o    index of the winning channel (valid when found_o=1)
module rr_pick_4
  import rr_arb_4ch_pkg::*;
(
  input  logic [NUM_CH-1:0] req_i,
  input  logic [SEL_W-1:0]  last_i,
  output logic              found_o,
  output logic [SEL_W-1:0]  idx_o
);

  pick_t pick;

  always_comb begin
    pick    = rr_pick(req_i, last_i);
    found_o = pick.found;
    idx_o   = pick.idx;
  end

endmodule

// File: rtl/rr_arb_4ch.sv
// Four-channel round-robin arbiter feeding a single registered output word.
// Latency: 1 cycle from input accept to out_valid; sustains 1 word/cycle.
// Backpressure: out_ready=0 while FULL holds the word and drops all in_ready.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   in_valid    per-channel request
//   in_data     packed channel words, channel i at [i*WIDTH +: WIDTH]
//   in_ready    one-hot (or zero) accept back to the winning channel
//   out_valid   output word present
//   out_data    registered winning word
//   out_sel     registered winning channel index (drives downstream mux)
//   out_ready   downstream accept
module rr_arb_4ch
  import rr_arb_4ch_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
);

  state_e             state_q;
  logic [SEL_W-1:0]   last_q;
  logic [WIDTH-1:0]   data_q;
  logic [SEL_W-1:0]   sel_q;

  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic               cap;
  logic               grant;
  logic [WIDTH-1:0]   data_d;
  logic [WIDTH-1:0]   ch_dat [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign ch_dat[i] = in_data[i*WIDTH +: WIDTH];
  end

  rr_pick_4 u_pick (
    .req_i   (in_valid),
    .last_i  (last_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // The output register can take a new word when it is empty or when the
  // word it holds leaves this cycle. Reset suppresses any grant so no
  // source believes it handed off a word that is about to be discarded.
  always_comb begin
    cap      = (state_q == EMPTY) || out_ready;
    grant    = !rst && cap && pick_found;
    data_d   = ch_dat[pick_idx];
    in_ready = '0;
    if (grant) begin
      in_ready[pick_idx] = 1'b1;
    end
  end

  // Output stage FSM. last_q resets to 3 so channel 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      last_q  <= 2'b11;
      data_q  <= '0;
      sel_q   <= '0;
    end else if (cap) begin
      if (pick_found) begin
        state_q <= FULL;
        data_q  <= data_d;
        sel_q   <= pick_idx;
        last_q  <= pick_idx;
      end else begin
        state_q <= EMPTY;
      end
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule

// File: tb/tb_rr_arb_4ch.sv
module tb_rr_arb_4ch;

  logic        clk;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;

  // WIDTH=1 build sees the LSB of each channel's 8-bit word.
  logic [3:0]  w1_in_data;
  logic [3:0]  w1_in_ready;
  logic        w1_out_valid;
  logic [0:0]  w1_out_data;
  logic [1:0]  w1_out_sel;

  assign w1_in_data = {in_data[24], in_data[16], in_data[8], in_data[0]};

  rr_arb_4ch #(.WIDTH(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  rr_arb_4ch #(.WIDTH(1)) u_dut_w1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (w1_in_data),
    .in_ready  (w1_in_ready),
    .out_valid (w1_out_valid),
    .out_data  (w1_out_data),
    .out_sel   (w1_out_sel),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] d;
    int         s;
  } word_t;

  word_t sb[$];
  bit    m_full = 1'b0;
  int    m_last = 3;
  int    wait_cnt[4] = '{0, 0, 0, 0};

  // Runs once per cycle after the monitor, with inputs settled: predicts
  // in_ready for this cycle and the word that will be registered next edge.
  always @(negedge clk) begin
    logic [3:0] exp_rdy;
    int g;
    #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_full});
    chk("w1_out_valid", {63'd0, w1_out_valid}, {63'd0, m_full});
    exp_rdy = 4'b0000;
    if (rst) begin
      m_full = 1'b0;
      m_last = 3;
      sb.delete();
      for (int c = 0; c < 4; c++) wait_cnt[c] = 0;
    end else if (!m_full || out_ready) begin
      g = -1;
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last + k) % 4;
        if (g < 0 && in_valid[c]) g = c;
      end
      if (g >= 0) begin
        word_t w;
        w.d = in_data[g*8 +: 8];
        w.s = g;
        sb.push_back(w);
        exp_rdy[g] = 1'b1;
        m_last = g;
        m_full = 1'b1;
        // A requester held valid must never be passed over 4 times.
        for (int c = 0; c < 4; c++) begin
          if (!in_valid[c] || c == g) wait_cnt[c] = 0;
          else begin
            wait_cnt[c]++;
            chk("fairness_wait", {63'd0, wait_cnt[c] <= 3}, 64'd1);
          end
        end
      end else begin
        m_full = 1'b0;
      end
    end
    chk("in_ready", {60'd0, in_ready}, {60'd0, exp_rdy});
    chk("w1_in_ready", {60'd0, w1_in_ready}, {60'd0, exp_rdy});
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_nonempty", 64'd0, 64'd1);
      end else begin
        chk("out_data", {56'd0, out_data}, {56'd0, sb[0].d});
        chk("out_sel", {62'd0, out_sel}, 64'(sb[0].s));
        chk("w1_out_data", {63'd0, w1_out_data}, {63'd0, sb[0].d[0]});
        chk("w1_out_sel", {62'd0, w1_out_sel}, 64'(sb[0].s));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic [3:0] v, input logic [31:0] d,
                       input logic o, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      rst       = r;
      in_valid  = v;
      in_data   = d;
      out_ready = o;
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 4'b0000;
    in_data   = 32'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_out_data", {56'd0, out_data}, 64'd0);
    chk("reset_out_sel", {62'd0, out_sel}, 64'd0);
    chk("reset_in_ready", {60'd0, in_ready}, 64'd0);

    // Full load, all channels, sink always ready (also the WIDTH=1 run).
    drive(1'b0, 4'b1111, 32'hDDCCBBAA, 1'b1, 6);
    drive(1'b0, 4'b0000, 32'h0, 1'b1, 2);

    // Backpressure on a single word.
    drive(1'b0, 4'b0100, 32'h005A0000, 1'b0, 5);
    drive(1'b0, 4'b0000, 32'h0, 1'b1, 2);

    // Fairness: ch0 continuous, ch3 joins.
    drive(1'b0, 4'b0001, 32'h300000C0, 1'b1, 3);
    drive(1'b0, 4'b1001, 32'h300000C0, 1'b1, 6);
    drive(1'b0, 4'b0000, 32'h0, 1'b1, 2);

    // Idle drain of a single word.
    drive(1'b0, 4'b0010, 32'h00001100, 1'b1, 1);
    drive(1'b0, 4'b0000, 32'h0, 1'b1, 3);

    // Reset while holding a word under backpressure.
    drive(1'b0, 4'b0001, 32'h00000077, 1'b1, 1);
    drive(1'b0, 4'b0000, 32'h0, 1'b0, 2);
    drive(1'b1, 4'b1111, 32'h44332211, 1'b0, 1);
    drive(1'b0, 4'b1111, 32'h44332211, 1'b1, 3);

    // Random traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) == 0), 4'($urandom), $urandom,
            ($urandom_range(0, 9) < 7), 1);
    end

    drive(1'b0, 4'b0000, 32'h0, 1'b1, 3);
    @(negedge clk);
    #3;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
